pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//  Generic parametrised pipeline stage register for the 5-stage core (IF/ID, ID/EX,
//  EX/MEM, MEM/WB). Carries a datapath payload plus a control bundle with valid/ready
//  flow control, synchronous flush (bubble insert) and an optional 2-entry skid buffer
//  that registers in_ready. Drops a bubble (control = 0) whenever the stage is empty.
//  Keeps a saturating counter of back-pressure cycles for performance debug.
// PARAMETERS
//  DATA_W      106  payload width (e.g. op1 32 + op2 32 + imm 32 + Rs/Rt/Rd 15 = 111 for ID/EX)
//  CTRL_W      10   control bundle width (RegWrite, MemtoReg, MemWrite, MemRead, ALUSrc, RegDst, ALUControl[3:0])
//  SKID        0    0 = single entry, in_ready combinational; 1 = two entries, in_ready registered
//  CLEAR_DATA  0    1 = flush also zeroes payload; 0 = payload holds on flush
//  CNT_W       16   width of stall_cnt
// PORTS
//  clk        in   1       rising-edge clock
//  clr        in   1       asynchronous active-high reset
//  flush      in   1       synchronous flush, active-high: invalidate all entries
//  in_valid   in   1       upstream has a stage payload
//  in_ready   out  1       stage accepts in_data/in_ctrl this cycle
//  in_data    in   DATA_W  upstream payload
//  in_ctrl    in   CTRL_W  upstream control bundle
//  out_valid  out  1       out_data/out_ctrl hold a live instruction
//  out_ready  in   1       downstream consumes this cycle (0 = stall)
//  out_data   out  DATA_W  registered payload
//  out_ctrl   out  CTRL_W  registered control; 0 whenever out_valid = 0
//  stall_cnt  out  CNT_W   cycles with out_valid & ~out_ready, saturating
// BEHAVIOUR
//  - Reset (clr=1, async): out_valid=0, out_data=0, out_ctrl=0, skid entry empty and zeroed,
//    stall_cnt=0, state EMPTY. in_ready=1 after release (0 while clr=1).
//  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. Latency 1 clk, in-order.
//  - SKID=0: in_ready = ~flush & (out_ready | ~out_valid) (comb). in_fire -> main <= in,
//    out_valid<=1; else out_fire -> out_valid<=0, out_ctrl<=0; else hold (stall).
//  - SKID=1: in_ready = ~skid_valid & ~flush (skid_valid is a flop). States:
//    EMPTY: in_fire -> ONE (main<=in).
//    ONE:   in_fire & out_fire -> ONE (main<=in); in_fire & ~out_ready -> TWO (skid<=in);
//           out_fire only -> EMPTY (out_ctrl<=0); neither -> ONE (hold).
//    TWO:   out_fire -> ONE (main<=skid, skid cleared); else hold. No accept in TWO.
//  - Flush (priority over all but clr): next state EMPTY, out_valid=0, skid_valid=0,
//    out_ctrl=0, skid ctrl=0; payload zeroed iff CLEAR_DATA=1. in_ready=0 during flush, so
//    in_valid on a flush cycle is dropped. out_fire on a flush cycle still counts as consumed.
//  - out_ctrl is never nonzero with out_valid=0 (bubble guarantee: no stray RegWrite/MemWrite).
//  - out_data holds its last value when empty (CLEAR_DATA=0); downstream must qualify with out_valid.
//  - stall_cnt: +1 each cycle out_valid & ~out_ready, saturates at 2^CNT_W-1, cleared only by clr.
//  - clr asserted mid-transfer: all state lost immediately; no partial entry survives.
// STRUCTURE
//  - pipe_pkg: stage state enum (EMPTY/ONE/TWO), CTRL bit positions (CTRL_REGWRITE,
//    CTRL_MEMTOREG, CTRL_MEMWRITE, CTRL_MEMREAD, CTRL_ALUSRC, CTRL_REGDST, CTRL_ALUOP_LSB/MSB),
//    default widths per stage (IDEX_DATA_W etc.).
//  - Sub-module pipe_entry: one storage slot (data, ctrl, valid) with load/clear inputs;
//    instanced once (SKID=0) or twice (SKID=1). Control FSM + counter in top.
// TESTING
//  1 Reset: clr=1 mid-stream with out_valid=1 -> next sample out_valid=0, out_ctrl=0, stall_cnt=0.
//  2 Stream, out_ready=1: in 0xA,0xB,0xC back-to-back -> out same order, 1-clk latency, no gaps,
//    in_ready stays 1 (both SKID settings).
//  3 Stall, SKID=1: out_ready=0 for 3 clk while sending 0x1,0x2,0x3 -> 0x1 held, 0x2 in skid,
//    in_ready=0 from cycle 2, 0x3 held upstream; release -> 0x1,0x2,0x3 in order; stall_cnt=3.
//  4 Flush in TWO with in_valid=1 & ctrl=0x3FF -> next cycle out_valid=0, out_ctrl=0,
//    in_ready=0 on flush cycle, incoming word not seen at output.
//  5 Drain: single word, out_ready=1, no new input -> out_valid falls, out_ctrl=0, out_data
//    retains word (CLEAR_DATA=0) or 0 (CLEAR_DATA=1).
//  6 Saturation, CNT_W=4: hold out_ready=0 for 20 clk with out_valid=1 -> stall_cnt=15, stays 15.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared stage-register types, control-bundle bit positions and per-stage widths
package pipe_pkg;
   typedef enum logic [1:0] {EMPTY, ONE, TWO} stage_state_e;
   localparam int CTRL_REGWRITE  = 9;
   localparam int CTRL_MEMTOREG  = 8;
   localparam int CTRL_MEMWRITE  = 7;
   localparam int CTRL_MEMREAD   = 6;
   localparam int CTRL_ALUSRC    = 5;
   localparam int CTRL_REGDST    = 4;
   localparam int CTRL_ALUOP_MSB = 3;
   localparam int CTRL_ALUOP_LSB = 0;
   localparam int DEF_CTRL_W     = CTRL_REGWRITE + 1;
   localparam int DEF_DATA_W     = 106;
   localparam int IFID_DATA_W    = 64;
   localparam int IDEX_DATA_W    = 111;
   localparam int EXMEM_DATA_W   = 69;
   localparam int MEMWB_DATA_W   = 69;
endpackage

// File: rtl/pipe_entry.sv
// pipe_entry: one stage storage slot; flush beats load, load beats unload
module pipe_entry import pipe_pkg::*; #(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int CTRL_W     = DEF_CTRL_W,
   parameter bit CLEAR_DATA = 1'b0
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              flush_i,
   input  logic              load_i,
   input  logic              unload_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [CTRL_W-1:0] ctrl_i,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o,
   output logic [CTRL_W-1:0] ctrl_o
);
   logic              valid_q, valid_d, kill;
   logic [DATA_W-1:0] data_q, data_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;

   // an emptied slot always carries a zero control bundle
   always_comb begin
      kill    = flush_i | (unload_i & ~load_i);
      valid_d = kill ? 1'b0 : (load_i | valid_q);
      ctrl_d  = kill ? '0 : load_i ? ctrl_i : ctrl_q;
      data_d  = kill ? (CLEAR_DATA ? '0 : data_q) : load_i ? data_i : data_q;
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         ctrl_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         ctrl_q  <= ctrl_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign ctrl_o  = ctrl_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register with flush, optional skid slot
// and a saturating back-pressure counter
module pipe_stage_reg import pipe_pkg::*; #(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int CTRL_W     = DEF_CTRL_W,
   parameter bit SKID       = 1'b0,
   parameter bit CLEAR_DATA = 1'b0,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [CNT_W-1:0]  stall_cnt
);
   stage_state_e      state_q, state_d;
   logic              in_fire, main_ld, main_unld, skid_valid;
   logic [DATA_W-1:0] skid_data, main_src_data;
   logic [CTRL_W-1:0] skid_ctrl, main_src_ctrl;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   // with a skid slot, in_ready depends only on flops (plus flush)
   assign in_ready = ~clr & ~flush & (SKID ? ~skid_valid : (out_ready | ~out_valid));
   assign in_fire  = in_valid & in_ready;

   always_comb begin
      state_d   = state_q;
      main_ld   = 1'b0;
      main_unld = 1'b0;
      if (flush) state_d = EMPTY;
      else case (state_q)
         EMPTY: begin
            main_ld = in_fire;
            state_d = in_fire ? ONE : EMPTY;
         end
         ONE: begin
            main_ld   = in_fire & out_ready;
            main_unld = ~in_fire & out_ready;
            state_d   = (in_fire & ~out_ready) ? TWO : main_unld ? EMPTY : ONE;
         end
         TWO: begin
            main_ld = out_ready;
            state_d = out_ready ? ONE : TWO;
         end
         default: state_d = EMPTY;
      endcase
   end

   always_comb begin
      main_src_data = (state_q == TWO) ? skid_data : in_data;
      main_src_ctrl = (state_q == TWO) ? skid_ctrl : in_ctrl;
      cnt_d         = (out_valid & ~out_ready & ~&cnt_q) ? cnt_q + CNT_W'(1) : cnt_q;
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q <= EMPTY;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CLEAR_DATA(CLEAR_DATA)) u_main (
      .clk(clk), .clr(clr), .flush_i(flush), .load_i(main_ld), .unload_i(main_unld),
      .data_i(main_src_data), .ctrl_i(main_src_ctrl),
      .valid_o(out_valid), .data_o(out_data), .ctrl_o(out_ctrl)
   );

   if (SKID) begin : g_skid
      pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CLEAR_DATA(CLEAR_DATA)) u_skid (
         .clk(clk), .clr(clr), .flush_i(flush),
         .load_i((state_q == ONE) & in_fire & ~out_ready),
         .unload_i((state_q == TWO) & out_ready),
         .data_i(in_data), .ctrl_i(in_ctrl),
         .valid_o(skid_valid), .data_o(skid_data), .ctrl_o(skid_ctrl)
      );
   end else begin : g_no_skid
      assign skid_valid = 1'b0;
      assign skid_data  = '0;
      assign skid_ctrl  = '0;
   end

   assign stall_cnt = cnt_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: a single-entry lane and a skid lane (CLEAR_DATA=1, CNT_W=4) under
// random traffic, scoreboarded against an occupancy-level model of the stage
module tb_pipe_stage_reg;
   localparam int DW = 32;
   localparam int CW = 10;
   localparam int WW = DW + CW;

   logic                 clk       = 1'b0;
   logic                 clr       = 1'b1;
   logic                 flush     = 1'b0;
   logic                 out_ready = 1'b0;
   logic [1:0]           in_valid  = '0;
   logic [1:0][DW-1:0]   in_data   = '0;
   logic [1:0][CW-1:0]   in_ctrl   = '0;
   wire  [1:0]           in_ready, out_valid;
   wire  [1:0][DW-1:0]   out_data;
   wire  [1:0][CW-1:0]   out_ctrl;
   wire  [15:0]          cnt0;
   wire  [3:0]           cnt1;

   logic [WW-1:0] mem [2][256];
   int            head [2]  = '{0, 0};
   int            tail [2]  = '{0, 0};
   int            mcnt [2]  = '{0, 0};
   logic [DW-1:0] last [2]  = '{'0, '0};
   bit            fired [2] = '{1'b0, 1'b0};
   int            n_cmp = 0;
   int            n_bad = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b0), .CLEAR_DATA(1'b0), .CNT_W(16)) u_dut0 (
      .clk(clk), .clr(clr), .flush(flush), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .in_data(in_data[0]), .in_ctrl(in_ctrl[0]), .out_valid(out_valid[0]), .out_ready(out_ready),
      .out_data(out_data[0]), .out_ctrl(out_ctrl[0]), .stall_cnt(cnt0)
   );

   pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b1), .CLEAR_DATA(1'b1), .CNT_W(4)) u_dut1 (
      .clk(clk), .clr(clr), .flush(flush), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .in_data(in_data[1]), .in_ctrl(in_ctrl[1]), .out_valid(out_valid[1]), .out_ready(out_ready),
      .out_data(out_data[1]), .out_ctrl(out_ctrl[1]), .stall_cnt(cnt1)
   );

   task automatic check(input string nm, input int l, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s lane%0d @%0t: got %0h expected %0h", nm, l, $time, act, exp);
      end
   endtask

   // accepted words enter the scoreboard after the edge that captured them
   task automatic cycle(input int pv, input int pr, input int pf, input bit c);
      @(posedge clk);
      #1;
      for (int l = 0; l < 2; l++) begin
         if (fired[l]) begin
            mem[l][tail[l] % 256] = {in_data[l], in_ctrl[l]};
            tail[l]++;
         end
         if (!in_valid[l] || fired[l] || flush) begin
            in_valid[l] = int'($urandom_range(99)) < pv;
            in_data[l]  = DW'($urandom);
            in_ctrl[l]  = ($urandom_range(3) == 0) ? '1 : CW'($urandom);
         end
      end
      clr       = c;
      out_ready = int'($urandom_range(99)) < pr;
      flush     = int'($urandom_range(99)) < pf;
      @(negedge clk);
      for (int l = 0; l < 2; l++) fired[l] = in_valid[l] && in_ready[l];
   endtask

   always @(negedge clk) begin
      int n;
      logic [63:0] cv;
      for (int l = 0; l < 2; l++) begin
         cv = (l == 0) ? 64'(cnt0) : 64'(cnt1);
         if (clr) begin
            check("reset_out_valid", l, 64'(out_valid[l]), 64'd0);
            check("reset_out_ctrl", l, 64'(out_ctrl[l]), 64'd0);
            check("reset_out_data", l, 64'(out_data[l]), 64'd0);
            check("reset_stall_cnt", l, cv, 64'd0);
            check("reset_in_ready", l, 64'(in_ready[l]), 64'd0);
            head[l] = tail[l];
            mcnt[l] = 0;
            last[l] = '0;
         end else begin
            n = tail[l] - head[l];
            check("in_ready", l, 64'(in_ready[l]), 64'(!flush && (l == 1 ? n < 2 : (n == 0 || out_ready))));
            check("out_valid", l, 64'(out_valid[l]), 64'(n > 0));
            check("stall_cnt", l, cv, 64'(mcnt[l]));
            if (n > 0) begin
               check("out_word", l, 64'({out_data[l], out_ctrl[l]}), 64'(mem[l][head[l] % 256]));
               last[l] = mem[l][head[l] % 256][WW-1:CW];
               if (out_ready) head[l]++;
               else if (mcnt[l] < (l == 0 ? 65535 : 15)) mcnt[l]++;
            end else begin
               check("bubble_ctrl", l, 64'(out_ctrl[l]), 64'd0);
               check("idle_data", l, 64'(out_data[l]), l == 1 ? 64'd0 : 64'(last[l]));
            end
            if (flush) head[l] = tail[l];
         end
      end
   end

   initial begin
      repeat (3) cycle(0, 0, 0, 1'b1);
      repeat (6) cycle(100, 100, 0, 1'b0);
      repeat (3) cycle(100, 0, 0, 1'b0);
      repeat (4) cycle(0, 100, 0, 1'b0);
      repeat (2) cycle(100, 0, 0, 1'b0);
      cycle(100, 0, 100, 1'b0);
      repeat (3) cycle(0, 100, 0, 1'b0);
      repeat (20) cycle(100, 0, 0, 1'b0);
      cycle(100, 50, 0, 1'b1);
      for (int s = 0; s < 6; s++) repeat (100) cycle(40 + 10 * s, 90 - 12 * s, s, 1'b0);
      repeat (5) cycle(0, 100, 0, 1'b0);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
